// File: rtl/ex_muldiv_seq.sv
// ---------------------------------------------------------------------------
// ex_muldiv_seq
//
// Iterative RV32M multiply/divide sequencer that sits beside the EX-stage ALU.
// One M-extension op is accepted from decode. It runs for XLEN cycles as a
// radix-2 shift-add multiply or a restoring divide. One fix-up cycle then
// applies the sign correction and selects the result word. The result and the
// rd address are presented with a one-cycle done pulse. The pipeline is held
// through stall_o while the op is in flight.
//
// Ports
//   clk_i     : clock, all state updates on the rising edge
//   rstn_i    : asynchronous active-low reset
//   start_i   : request a new op (sampled only in IDLE)
//   op_i      : funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   src_A_i   : rs1 operand
//   src_B_i   : rs2 operand
//   rd_i      : destination register index
//   flush_i   : abort the in-flight op (trap / branch redirect)
//   busy_o    : registered, high in CALC, FIX and DONE
//   stall_o   : combinational pipeline hold request
//   done_o    : one-cycle result-valid pulse
//   result_o  : result, valid while done_o is high, held otherwise
//   rd_o      : latched rd, valid while done_o is high
// ---------------------------------------------------------------------------
module ex_muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] src_A_i,
    input  logic [XLEN-1:0] src_B_i,
    input  logic [4:0]      rd_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_o
);

    localparam int CNT_W = $clog2(XLEN);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Two's-complement negate when neg is set; used for absolute values and
    // for the final sign correction.
    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v,
                                                 input logic            neg);
        cond_neg = neg ? (~v + XLEN'(1)) : v;
    endfunction

    function automatic logic [2*XLEN-1:0] cond_neg_wide(input logic [2*XLEN-1:0] v,
                                                        input logic              neg);
        cond_neg_wide = neg ? (~v + (2*XLEN)'(1)) : v;
    endfunction

    state_t              state_r, state_nxt;
    logic [CNT_W-1:0]    cnt_r;
    logic [2:0]          op_r;
    logic [4:0]          rd_r;
    logic                neg_q_r;     // operand signs differ: negate product / quotient
    logic                neg_r_r;     // dividend negative: negate remainder
    logic [XLEN-1:0]     b_r;         // |multiplicand| or |divisor|
    logic [2*XLEN-1:0]   acc_r;       // product, or remainder:quotient
    logic [XLEN-1:0]     result_r;
    logic                busy_r;

    // ---------------- Decode of the incoming request ----------------
    logic            a_sgn_in, b_sgn_in, sa_in, sb_in;
    logic [XLEN-1:0] abs_a_in, abs_b_in;
    logic            div0_in, ovf_in, special_in, accept;
    logic [XLEN-1:0] special_res;

    always_comb begin
        a_sgn_in = (op_i == OP_MULH) || (op_i == OP_MULHSU) ||
                   (op_i == OP_DIV)  || (op_i == OP_REM);
        b_sgn_in = (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
        sa_in    = a_sgn_in & src_A_i[XLEN-1];
        sb_in    = b_sgn_in & src_B_i[XLEN-1];
        abs_a_in = cond_neg(src_A_i, sa_in);
        abs_b_in = cond_neg(src_B_i, sb_in);

        // Divide by zero and the signed overflow case have architecturally
        // fixed results, so they bypass the iteration entirely.
        div0_in    = op_i[2] && (src_B_i == '0);
        ovf_in     = op_i[2] && !op_i[0] && (src_A_i == MOST_NEG) && (src_B_i == '1);
        special_in = div0_in || ovf_in;

        special_res = '0;
        if (div0_in) begin
            special_res = op_i[1] ? src_A_i : '1;
        end else if (ovf_in) begin
            special_res = op_i[1] ? '0 : MOST_NEG;
        end

        accept = (state_r == S_IDLE) && start_i && !flush_i;
    end

    // ---------------- One iteration step ----------------
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     rem_sh;
    logic [XLEN:0]     div_diff;
    logic [XLEN-1:0]   q_sh;
    logic [2*XLEN-1:0] div_next;

    always_comb begin
        // Shift-add: the multiplier sits in the low half and is consumed LSB
        // first; the carry out of the add becomes the new MSB after the shift.
        mul_sum  = {1'b0, acc_r[2*XLEN-1:XLEN]} + (acc_r[0] ? {1'b0, b_r} : '0);
        mul_next = {mul_sum, acc_r[XLEN-1:1]};

        // Restoring divide: the partial remainder is always below the divisor,
        // so one extra bit holds the shifted value and the borrow.
        rem_sh   = {acc_r[2*XLEN-1:XLEN], acc_r[XLEN-1]};
        div_diff = rem_sh - {1'b0, b_r};
        q_sh     = {acc_r[XLEN-2:0], ~div_diff[XLEN]};
        div_next = div_diff[XLEN] ? {rem_sh[XLEN-1:0], q_sh}
                                  : {div_diff[XLEN-1:0], q_sh};
    end

    // ---------------- Sign correction and word select ----------------
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;

    always_comb begin
        prod_fix = cond_neg_wide(acc_r, neg_q_r);
        quo_fix  = cond_neg(acc_r[XLEN-1:0], neg_q_r);
        rem_fix  = cond_neg(acc_r[2*XLEN-1:XLEN], neg_r_r);
        unique case (op_r)
            OP_MUL:                        fix_res = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  fix_res = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               fix_res = quo_fix;
            default:                       fix_res = rem_fix;
        endcase
    end

    // ---------------- Next state and stall request ----------------
    always_comb begin
        state_nxt = state_r;
        stall_o   = 1'b0;
        unique case (state_r)
            S_IDLE: begin
                stall_o = start_i & ~flush_i;
                if (accept) begin
                    state_nxt = special_in ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                stall_o = 1'b1;
                if (flush_i) begin
                    state_nxt = S_IDLE;
                end else if (cnt_r == CNT_W'(XLEN-1)) begin
                    state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                stall_o   = 1'b1;
                state_nxt = flush_i ? S_IDLE : S_DONE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ---------------- State and datapath registers ----------------
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_r  <= S_IDLE;
            cnt_r    <= '0;
            op_r     <= '0;
            rd_r     <= '0;
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            b_r      <= '0;
            acc_r    <= '0;
            result_r <= '0;
            busy_r   <= 1'b0;
        end else begin
            state_r <= state_nxt;
            busy_r  <= (state_nxt != S_IDLE);
            if (accept) begin
                op_r    <= op_i;
                rd_r    <= rd_i;
                neg_q_r <= sa_in ^ sb_in;
                neg_r_r <= sa_in;
                b_r     <= abs_b_in;
                acc_r   <= {{XLEN{1'b0}}, abs_a_in};
                cnt_r   <= '0;
                if (special_in) begin
                    result_r <= special_res;
                end
            end else if ((state_r == S_CALC) && !flush_i) begin
                acc_r <= op_r[2] ? div_next : mul_next;
                cnt_r <= cnt_r + CNT_W'(1);
            end else if ((state_r == S_FIX) && !flush_i) begin
                result_r <= fix_res;
            end
        end
    end

    assign busy_o   = busy_r;
    assign done_o   = (state_r == S_DONE);
    assign result_o = result_r;
    assign rd_o     = rd_r;

endmodule
